// File: rtl/seq_detect_ctrl_if.sv
// Word-in / count-out handshake bundle for the 1010 sequence detector.
// The master side offers words and takes results; the slave side is the detector.
interface seq_detect_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serialises a word MSB first through a 1010 overlapping detector and reports
// the saturating match count through a valid/ready result handshake.
module seq_detect_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter bit CHAIN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  seq_detect_ctrl_if.slave bus,
  output logic             ser_bit,
  output logic             ser_en,
  output logic             match,
  output logic             busy
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    REPORT = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] word_r;
  logic [IDX_W-1:0] idx_r;
  logic [2:0]       hist_r;
  logic [CNT_W-1:0] count_r;
  logic             alive_r;
  logic             accept_s;
  logic             cur_bit_s;

  // alive_r holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_r <= 1'b0;
    end else begin
      alive_r <= 1'b1;
    end
  end

  // controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode; a word is only taken in IDLE, never in the handshake cycle
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && alive_r) begin
          state_s  = SHIFT;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (idx_r == LAST_IDX) begin
          state_s = REPORT;
        end else begin
          state_s = SHIFT;
        end
      end
      REPORT: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = REPORT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // output decode from the registered state and the current serial bit
  always_comb begin
    cur_bit_s     = word_r[LAST_IDX - idx_r];
    bus.in_ready  = alive_r && (state_r == IDLE);
    busy          = (state_r != IDLE);
    ser_en        = (state_r == SHIFT);
    ser_bit       = 1'b0;
    match         = 1'b0;
    bus.out_valid = (state_r == REPORT);
    bus.out_count = '0;
    if (ser_en) begin
      ser_bit = cur_bit_s;
      match   = ({hist_r, cur_bit_s} == 4'b1010);
    end else begin
      ser_bit = 1'b0;
      match   = 1'b0;
    end
    if (bus.out_valid) begin
      bus.out_count = count_r;
    end else begin
      bus.out_count = '0;
    end
  end

  // word capture, bit walk, detector history and saturating match count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_r  <= '0;
      idx_r   <= '0;
      hist_r  <= 3'b000;
      count_r <= '0;
    end else if (accept_s) begin
      word_r  <= bus.in_data;
      idx_r   <= '0;
      count_r <= '0;
      if (CHAIN == 1'b0) begin
        hist_r <= 3'b000;
      end
    end else if (state_r == SHIFT) begin
      hist_r <= {hist_r[1:0], cur_bit_s};
      idx_r  <= idx_r + IDX_W'(1);
      if (match && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end
endmodule
